// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide.
// Optional MULDIV_ZERO_BYPASS_EN skips iteration for zero-operand requests.
module muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [2:0]      op;
    logic [W-1:0]    a_raw;
    logic [W-1:0]    dvs;
    logic [W-1:0]    acc_hi;
    logic [W-1:0]    acc_lo;
    logic [CW-1:0]   cnt;
    logic            b_zero;
    logic            neg_q;
    logic            neg_r;

    // Operand decode at capture time
    logic            sgn_a_in, sgn_b_in, neg_a_in, neg_b_in, bypass_in;
    logic [W-1:0]    a_mag_in, b_mag_in;

    assign sgn_a_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sgn_b_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign neg_a_in = sgn_a_in & SrcA[W-1];
    assign neg_b_in = sgn_b_in & SrcB[W-1];
    assign a_mag_in = neg_a_in ? W'(-SrcA) : SrcA;
    assign b_mag_in = neg_b_in ? W'(-SrcB) : SrcB;

`ifdef MULDIV_ZERO_BYPASS_EN
    assign bypass_in = funct3[2] ? (SrcB == '0) : ((SrcA == '0) || (SrcB == '0));
`else
    assign bypass_in = 1'b0;
`endif

    // One iteration step for each algorithm
    logic [W:0] mul_sum, div_shift, div_diff;
    logic       div_ok;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : (W+1)'(0));
    assign div_shift = {acc_hi, acc_lo[W-1]};
    assign div_diff  = div_shift - {1'b0, dvs};
    assign div_ok    = ~div_diff[W];

    // Sign correction and result select
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, res_c;

    assign prod     = {acc_hi, acc_lo};
    assign prod_fix = neg_q ? (2*W)'(-prod) : prod;
    assign quo_fix  = neg_q ? W'(-acc_lo) : acc_lo;
    assign rem_fix  = neg_r ? W'(-acc_hi) : acc_hi;

    always_comb begin
        res_c = '0;
        case (op)
            3'b000:                 res_c = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: res_c = prod_fix[2*W-1:W];
            3'b100, 3'b101:         res_c = b_zero ? '1 : quo_fix;
            default:                res_c = b_zero ? a_raw : rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op     <= '0;
            a_raw  <= '0;
            dvs    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            b_zero <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op     <= funct3;
                        a_raw  <= SrcA;
                        b_zero <= (SrcB == '0);
                        neg_q  <= neg_a_in ^ neg_b_in;
                        neg_r  <= neg_a_in;
                        cnt    <= '0;
                        acc_hi <= '0;
                        busy   <= 1'b1;
                        if (funct3[2]) begin
                            acc_lo <= a_mag_in;
                            dvs    <= b_mag_in;
                        end else begin
                            acc_lo <= bypass_in ? '0 : b_mag_in;
                            dvs    <= a_mag_in;
                        end
                        state <= bypass_in ? FIX : CALC;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (op[2]) begin
                        acc_hi <= div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
                        acc_lo <= {acc_lo[W-2:0], div_ok};
                    end else begin
                        acc_hi <= mul_sum[W:1];
                        acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
                    end
                    if (cnt == CW'(31)) state <= FIX;
                end
                FIX: begin
                    Result <= res_c;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: results, latency, busy window, reset abort, back-to-back.
module tb_muldiv;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] SrcA, SrcB;
    logic        busy, done;
    logic [31:0] Result;

    int total = 0;
    int bad   = 0;
    bit hold  = 0;

    muldiv dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit byp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_ZERO_BYPASS_EN
        return f[2] ? (b == 0) : ((a == 0) || (b == 0));
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int edges, busyc, lat;
        bit seen;
        lat = byp(f, a, b) ? 2 : 34;
        funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
        edges = 0; busyc = 0; seen = 0;
        while (!seen && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (busy) busyc++;
            if (done) seen = 1;
            if (!done && edges >= 2 && edges <= 30) begin
                SrcA = $urandom; SrcB = $urandom; funct3 = 3'($urandom);
            end else begin
                SrcA = a; SrcB = b; funct3 = f;
            end
        end
        chk({tag, ":done"}, 32'(seen), 32'd1);
        chk({tag, ":result"}, Result, exp);
        chk({tag, ":latency"}, 32'(edges), 32'(lat));
        chk({tag, ":busy_cycles"}, 32'(busyc), 32'(lat - 1));
        @(negedge clk);
        chk({tag, ":done_pulse"}, 32'(done), 32'd0);
        chk({tag, ":held"}, Result, exp);
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0; start = 1'b0; funct3 = '0; SrcA = '0; SrcB = '0;
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", Result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
        do_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
        do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        do_op(3'b001, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, "mulh_neg");
        do_op(3'b011, 32'h12345678, 32'h00000010, 32'h00000001, "mulhu_small");
        do_op(3'b000, 32'h00000000, 32'h00000005, 32'h00000000, "mul_zero");
        do_op(3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, "div");
        do_op(3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, "rem");
        do_op(3'b101, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, "divu");
        do_op(3'b111, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, "remu");
        do_op(3'b100, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, "div_negb");
        do_op(3'b110, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, "rem_negb");
        do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");
        do_op(3'b111, 32'h00001234, 32'h00000000, 32'h00001234, "remu_by0");
        do_op(3'b100, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, "div_by0");
        do_op(3'b101, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, "divu_by0");
        do_op(3'b110, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, "rem_by0");

        // Reset in the middle of CALC abandons the request
        funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", Result, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        do_op(3'b101, 32'd100, 32'd7, 32'd14, "divu_after_reset");

        // start held high: consecutive requests accepted right after DONE
        hold = 1;
        do_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, "hold1");
        do_op(3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, "hold2");
        hold = 0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameters: none; operand width fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SrcA  input  32  rs1 operand (multiplicand / dividend).
REQ-007 SrcB  input  32  rs2 operand (multiplier / divisor).
REQ-008 busy  output  1  high while a request is in progress (CALC or FIX).
REQ-009 done  output  1  one-cycle pulse; Result valid in that cycle.
REQ-010 Result  output  32  registered result; holds until the next completion.

Function
REQ-011 FSM states: IDLE, CALC, FIX, DONE; transitions only on the rising edge of clk.
REQ-012 IDLE: start=1 captures funct3, SrcA, SrcB and the 5-bit iteration counter (=0), then enters CALC; start=0 stays in IDLE.
REQ-013 start is ignored in CALC/FIX/DONE; the captured operands are not disturbed by input changes.
REQ-014 CALC performs exactly one iteration per cycle for 32 cycles, then enters FIX.
REQ-015 Multiply: shift-add on operand magnitudes into a 64-bit product.
REQ-016 Multiply signedness: MULH is signed x signed; MULHSU is signed SrcA x unsigned SrcB; MULHU and MUL are unsigned.
REQ-017 Multiply result select: MUL returns product[31:0]; the MULH variants return product[63:32].
REQ-018 Divide: restoring division on operand magnitudes; DIV/REM are signed, DIVU/REMU unsigned.
REQ-019 Divide signs: quotient is negated when operand signs differ; the remainder takes the dividend's sign.
REQ-020 FIX applies sign correction and selects the result, registers it into Result, then enters DONE.
REQ-021 DONE: done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-022 Latency: start sampled at edge N -> done high in the cycle following edge N+33 (34 edges); back-to-back start is accepted in the IDLE cycle after DONE.
REQ-023 busy=1 exactly in CALC and FIX; busy=0 in IDLE and DONE.
REQ-024 Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> SrcA; latency as REQ-022 unless REQ-030 applies.
REQ-025 Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0x00000000.
REQ-026 All arithmetic is modulo 2^32 on Result; no exception flag is produced.

Reset
REQ-027 rst_n=0 immediately forces IDLE, busy=0, done=0, Result=0, counter=0, and clears the operand/accumulator registers, regardless of clk.
REQ-028 Reset asserted mid-operation abandons the request; no done pulse follows deassertion.
REQ-029 First start is accepted on the first rising edge with rst_n=1.

Configuration
REQ-030 MULDIV_ZERO_BYPASS_EN defined: in IDLE, a start where a multiply has SrcA==0 or SrcB==0, or a divide has SrcB==0, goes IDLE->FIX directly.
REQ-031 Bypass results: the REQ-024 results, or 0 for multiply; done appears after 2 edges; busy=1 during FIX only.
REQ-032 MULDIV_ZERO_BYPASS_EN undefined: every request takes the REQ-022 latency, with results per REQ-024.

Verification
REQ-033 MUL 0x00000007 x 0xFFFFFFFD -> Result 0xFFFFFFEB, done exactly 34 edges after start, busy high for 33 cycles.
REQ-034 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 0x00000001.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REMU 0x1234/0 -> 0x1234 after 34 edges (undefined macro) or 2 edges (defined macro).
REQ-037 rst_n pulsed low at cycle 10 of CALC -> busy=0 and Result=0 immediately, no done; new DIVU 100/7 -> 14 with nominal latency.
REQ-038 start held high continuously -> one done per 35 cycles; input changes during CALC do not alter Result.
